// File: rtl/usb_pkg.sv
// Shared types and constants for the USB full-speed endpoint blocks.
//   buf_state_t : life cycle of one IN packet buffer
//   tx_state_t  : transmit-side sequencing of one IN transaction
//   DATA0/DATA1/NAK/STALL : PID codes as sent on the wire
//   data_pid()  : data PID for a given toggle value
package usb_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2,
        TX    = 2'd3
    } buf_state_t;

    typedef enum logic [1:0] {
        TX_IDLE     = 2'd0,
        TX_SEND     = 2'd1,
        TX_WAIT_ACK = 2'd2
    } tx_state_t;

    localparam logic [3:0] DATA0 = 4'b0011;
    localparam logic [3:0] DATA1 = 4'b1011;
    localparam logic [3:0] NAK   = 4'b1010;
    localparam logic [3:0] STALL = 4'b1110;

    function automatic logic [3:0] data_pid(input logic toggle);
        return toggle ? DATA1 : DATA0;
    endfunction

endpackage

// File: rtl/usb_in_pkt_ram.sv
// Packet storage for the IN endpoint: 2**AW bytes.
//   clk     : clock
//   wr_en   : write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr : write address {buffer index, byte index}
//   wr_data : write byte
//   rd_addr : read address {buffer index, byte index}
//   rd_data : byte at rd_addr, combinational (show-ahead for the transmitter)
module usb_in_pkt_ram #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/usb_in_ep_buffer.sv
// Ping-pong IN endpoint buffer between an endpoint client and the USB FS
// transmit path. The client fills one buffer while the other one is sent.
//   clk, reset        : clock, synchronous active-high reset
//   in_ep_req/grant   : client arbitration (single client, grant = req)
//   in_ep_data_*      : client byte write (free/put/data) and packet close (done)
//   in_ep_stall       : arm a sticky STALL answer
//   in_ep_acked       : 1-cycle pulse when the host ACKed a packet
//   setup_seen        : SETUP token, flushes the endpoint and forces DATA1
//   tx_pkt_start      : IN token for this endpoint
//   tx_data_*         : show-ahead byte stream for the transmitter
//   tx_data_toggle    : 0 = DATA0, 1 = DATA1
//   tx_pkt_stall/nak  : 1-cycle handshake requests
//   rx_ack/tx_timeout : host handshake outcome
module usb_in_ep_buffer
    import usb_pkg::*;
#(
    parameter int MAX_PKT_SIZE = 32,
    parameter int PTR_W        = $clog2(MAX_PKT_SIZE) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_ep_req,
    output logic       in_ep_grant,
    output logic       in_ep_data_free,
    input  logic       in_ep_data_put,
    input  logic [7:0] in_ep_data,
    input  logic       in_ep_data_done,
    input  logic       in_ep_stall,
    output logic       in_ep_acked,
    input  logic       setup_seen,
    input  logic       tx_pkt_start,
    output logic       tx_data_avail,
    input  logic       tx_data_get,
    output logic [7:0] tx_data,
    output logic       tx_data_toggle,
    output logic       tx_pkt_stall,
    output logic       tx_pkt_nak,
    input  logic       rx_ack,
    input  logic       tx_timeout
);

    localparam logic [PTR_W-1:0] MAX_CNT = PTR_W'(MAX_PKT_SIZE);

    buf_state_t       buf_state_reg [2];
    buf_state_t       buf_state_next [2];
    logic [PTR_W-1:0] len_reg [2];
    logic [PTR_W-1:0] len_next [2];

    logic             fill_sel_reg, fill_sel_next;
    logic             send_sel_reg, send_sel_next;
    logic [PTR_W-1:0] wr_cnt_reg, wr_cnt_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic             toggle_reg, toggle_next;
    logic             stall_reg, stall_next;
    tx_state_t        tx_state_reg, tx_state_next;
    logic             acked_reg, acked_next;
    logic             stall_pulse_reg, stall_pulse_next;
    logic             nak_reg, nak_next;

    logic             fill_open, put_ok, fill_close;
    logic [PTR_W-1:0] wr_cnt_inc;
    logic [PTR_W-1:0] send_len;
    logic             tx_begin, tx_release, tx_requeue;

    // ---------------- fill side ----------------
    assign fill_open       = (buf_state_reg[fill_sel_reg] == FREE) ||
                             (buf_state_reg[fill_sel_reg] == FILL);
    assign in_ep_data_free = fill_open && (wr_cnt_reg < MAX_CNT);
    assign put_ok          = in_ep_data_put && in_ep_data_free;
    assign wr_cnt_inc      = wr_cnt_reg + PTR_W'(put_ok);
    // A byte written together with done is part of the packet, and the last
    // byte that fills the buffer closes it without waiting for done.
    assign fill_close      = fill_open &&
                             (in_ep_data_done || (put_ok && wr_cnt_reg == MAX_CNT - 1'b1));
    assign wr_cnt_next     = fill_close ? '0 : wr_cnt_inc;
    assign fill_sel_next   = fill_sel_reg ^ fill_close;
    assign in_ep_grant     = in_ep_req;

    usb_in_pkt_ram #(.AW(PTR_W)) u_ram (
        .clk     (clk),
        .wr_en   (put_ok),
        .wr_addr ({fill_sel_reg, wr_cnt_reg[PTR_W-2:0]}),
        .wr_data (in_ep_data),
        .rd_addr ({send_sel_reg, rd_ptr_reg[PTR_W-2:0]}),
        .rd_data (tx_data)
    );

    // ---------------- per-buffer state ----------------
    // The fill side only touches a FREE/FILL buffer and the send side only a
    // READY/TX buffer, so both can act in one cycle without conflicting.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_buf
            logic fill_hit, send_hit;
            assign fill_hit = (fill_sel_reg == 1'(gi));
            assign send_hit = (send_sel_reg == 1'(gi));
            assign buf_state_next[gi] = (fill_hit && fill_close) ? READY :
                                        (fill_hit && put_ok)     ? FILL  :
                                        (send_hit && tx_begin)   ? TX    :
                                        (send_hit && tx_release) ? FREE  :
                                        (send_hit && tx_requeue) ? READY :
                                        buf_state_reg[gi];
            assign len_next[gi] = (fill_hit && fill_close) ? wr_cnt_inc : len_reg[gi];
        end
    endgenerate

    // ---------------- transmit FSM ----------------
    assign send_len       = len_reg[send_sel_reg];
    assign tx_data_avail  = (tx_state_reg == TX_SEND) && (rd_ptr_reg < send_len);
    assign tx_data_toggle = toggle_reg;
    assign stall_next     = stall_reg | in_ep_stall;

    always_comb begin
        tx_state_next    = tx_state_reg;
        rd_ptr_next      = rd_ptr_reg;
        toggle_next      = toggle_reg;
        send_sel_next    = send_sel_reg;
        tx_begin         = 1'b0;
        tx_release       = 1'b0;
        tx_requeue       = 1'b0;
        acked_next       = 1'b0;
        stall_pulse_next = 1'b0;
        nak_next         = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (tx_pkt_start) begin
                    if (stall_reg) begin
                        stall_pulse_next = 1'b1;
                    end else if (buf_state_reg[send_sel_reg] == READY) begin
                        tx_begin      = 1'b1;
                        rd_ptr_next   = '0;
                        tx_state_next = TX_SEND;
                    end else begin
                        nak_next = 1'b1;
                    end
                end
            end
            TX_SEND: begin
                if (tx_data_get && tx_data_avail) begin
                    rd_ptr_next = rd_ptr_reg + 1'b1;
                end
                if (rd_ptr_reg == send_len) begin
                    tx_state_next = TX_WAIT_ACK;
                end
            end
            TX_WAIT_ACK: begin
                if (rx_ack) begin
                    tx_release    = 1'b1;
                    toggle_next   = ~toggle_reg;
                    acked_next    = 1'b1;
                    send_sel_next = ~send_sel_reg;
                    tx_state_next = TX_IDLE;
                end else if (tx_timeout) begin
                    tx_requeue    = 1'b1;
                    tx_state_next = TX_IDLE;
                end else if (tx_pkt_start) begin
                    // Host lost our data and asked again: implied timeout, then a
                    // fresh token. The buffer stays in TX unless STALL is armed.
                    if (stall_reg) begin
                        tx_requeue       = 1'b1;
                        stall_pulse_next = 1'b1;
                        tx_state_next    = TX_IDLE;
                    end else begin
                        rd_ptr_next   = '0;
                        tx_state_next = TX_SEND;
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (reset || setup_seen) begin
            for (int b = 0; b < 2; b++) begin
                buf_state_reg[b] <= FREE;
                len_reg[b]       <= '0;
            end
            fill_sel_reg    <= 1'b0;
            send_sel_reg    <= 1'b0;
            wr_cnt_reg      <= '0;
            rd_ptr_reg      <= '0;
            stall_reg       <= 1'b0;
            tx_state_reg    <= TX_IDLE;
            acked_reg       <= 1'b0;
            stall_pulse_reg <= 1'b0;
            nak_reg         <= 1'b0;
            // SETUP always starts the data stage with DATA1.
            toggle_reg      <= !reset;
        end else begin
            for (int b = 0; b < 2; b++) begin
                buf_state_reg[b] <= buf_state_next[b];
                len_reg[b]       <= len_next[b];
            end
            fill_sel_reg    <= fill_sel_next;
            send_sel_reg    <= send_sel_next;
            wr_cnt_reg      <= wr_cnt_next;
            rd_ptr_reg      <= rd_ptr_next;
            stall_reg       <= stall_next;
            tx_state_reg    <= tx_state_next;
            acked_reg       <= acked_next;
            stall_pulse_reg <= stall_pulse_next;
            nak_reg         <= nak_next;
            toggle_reg      <= toggle_next;
        end
    end

    assign in_ep_acked  = acked_reg;
    assign tx_pkt_stall = stall_pulse_reg;
    assign tx_pkt_nak   = nak_reg;

endmodule

// File: tb/tb_usb_in_ep_buffer.sv
// Self-checking bench for usb_in_ep_buffer: a table of single-cycle vectors
// followed by hand-written multi-cycle packet sequences.
module tb_usb_in_ep_buffer;

    localparam int MAX = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_ep_req, in_ep_grant, in_ep_data_free, in_ep_data_put;
    logic [7:0] in_ep_data;
    logic       in_ep_data_done, in_ep_stall, in_ep_acked, setup_seen;
    logic       tx_pkt_start, tx_data_avail, tx_data_get;
    logic [7:0] tx_data;
    logic       tx_data_toggle, tx_pkt_stall, tx_pkt_nak, rx_ack, tx_timeout;

    usb_in_ep_buffer #(.MAX_PKT_SIZE(MAX)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_ep_req       (in_ep_req),
        .in_ep_grant     (in_ep_grant),
        .in_ep_data_free (in_ep_data_free),
        .in_ep_data_put  (in_ep_data_put),
        .in_ep_data      (in_ep_data),
        .in_ep_data_done (in_ep_data_done),
        .in_ep_stall     (in_ep_stall),
        .in_ep_acked     (in_ep_acked),
        .setup_seen      (setup_seen),
        .tx_pkt_start    (tx_pkt_start),
        .tx_data_avail   (tx_data_avail),
        .tx_data_get     (tx_data_get),
        .tx_data         (tx_data),
        .tx_data_toggle  (tx_data_toggle),
        .tx_pkt_stall    (tx_pkt_stall),
        .tx_pkt_nak      (tx_pkt_nak),
        .rx_ack          (rx_ack),
        .tx_timeout      (tx_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, put;
        logic [7:0] data;
        logic       done, stall, setup, start, get, ack, tmo;
        logic       e_free, e_avail, chk_data;
        logic [7:0] e_data;
        logic       e_tog, e_acked, e_stall, e_nak;
    } vec_t;

    localparam int NV = 30;
    vec_t       vecs [NV];
    logic [7:0] exp_bytes [64];
    int         checks = 0;
    int         errors = 0;

    function automatic vec_t v(input logic rst, put, input logic [7:0] data,
                               input logic done, stall, setup, start, get, ack, tmo,
                               input logic e_free, e_avail, chk_data,
                               input logic [7:0] e_data,
                               input logic e_tog, e_acked, e_stall, e_nak);
        vec_t r;
        r.rst = rst; r.put = put; r.data = data; r.done = done; r.stall = stall;
        r.setup = setup; r.start = start; r.get = get; r.ack = ack; r.tmo = tmo;
        r.e_free = e_free; r.e_avail = e_avail; r.chk_data = chk_data; r.e_data = e_data;
        r.e_tog = e_tog; r.e_acked = e_acked; r.e_stall = e_stall; r.e_nak = e_nak;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr();
        in_ep_data_put = 0; in_ep_data = 8'h00; in_ep_data_done = 0; in_ep_stall = 0;
        setup_seen = 0; tx_pkt_start = 0; tx_data_get = 0; rx_ack = 0; tx_timeout = 0;
    endtask

    task automatic do_reset();
        reset = 1; tick(); reset = 0;
    endtask

    task automatic put_byte(input logic [7:0] d, input logic done);
        in_ep_data_put = 1; in_ep_data = d; in_ep_data_done = done;
        tick(); clr();
    endtask

    task automatic start_token();
        tx_pkt_start = 1; tick(); clr();
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s avail[%0d]", tag, i), 8'(tx_data_avail), 8'h01);
            chk($sformatf("%s data[%0d]", tag, i), tx_data, exp_bytes[i]);
            tx_data_get = 1; tick(); clr();
        end
        chk($sformatf("%s avail_end", tag), 8'(tx_data_avail), 8'h00);
    endtask

    task automatic ack_packet(input string tag, input logic exp_tog);
        tick();                      // TX_SEND -> TX_WAIT_ACK
        rx_ack = 1; tick(); clr();
        chk($sformatf("%s acked", tag), 8'(in_ep_acked), 8'h01);
        chk($sformatf("%s toggle_after", tag), 8'(tx_data_toggle), 8'(exp_tog));
        $display("packet %s acknowledged, toggle now %0d", tag, tx_data_toggle);
    endtask

    initial begin
        //            rst put data  dn st su sta get ack tmo | free avail chk data  tog ack stl nak
        vecs[0]  = v(0, 1, 8'h11, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[1]  = v(0, 1, 8'h12, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[2]  = v(0, 1, 8'h13, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[3]  = v(0, 1, 8'h14, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[4]  = v(0, 1, 8'h15, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[5]  = v(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[6]  = v(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0,   1, 1, 1, 8'h11, 0, 0, 0, 0);
        vecs[7]  = v(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0,   1, 1, 1, 8'h12, 0, 0, 0, 0);
        vecs[8]  = v(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0,   1, 1, 1, 8'h13, 0, 0, 0, 0);
        vecs[9]  = v(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0,   1, 1, 1, 8'h14, 0, 0, 0, 0);
        vecs[10] = v(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0,   1, 1, 1, 8'h15, 0, 0, 0, 0);
        vecs[11] = v(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[12] = v(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[13] = v(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[14] = v(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 8'h00, 1, 1, 0, 0);
        vecs[15] = v(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 8'h00, 1, 0, 0, 0);
        vecs[16] = v(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 8'h00, 1, 0, 0, 1);
        vecs[17] = v(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 8'h00, 1, 0, 0, 0);
        vecs[18] = v(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[19] = v(0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[20] = v(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 8'h00, 0, 0, 1, 0);
        vecs[21] = v(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[22] = v(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 8'h00, 0, 0, 1, 0);
        vecs[23] = v(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 8'h00, 1, 0, 0, 0);
        vecs[24] = v(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 8'h00, 1, 0, 0, 0);
        vecs[25] = v(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 8'h00, 1, 0, 0, 0);
        vecs[26] = v(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 8'h00, 1, 0, 0, 0);
        vecs[27] = v(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 8'h00, 0, 1, 0, 0);
        vecs[28] = v(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[29] = v(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 8'h00, 0, 0, 0, 1);

        in_ep_req = 1; clr();
        reset = 1; tick(); tick(); reset = 0;

        // reset state
        chk("rst free", 8'(in_ep_data_free), 8'h01);
        chk("rst avail", 8'(tx_data_avail), 8'h00);
        chk("rst toggle", 8'(tx_data_toggle), 8'h00);
        chk("rst pulses", {5'b0, in_ep_acked, tx_pkt_stall, tx_pkt_nak}, 8'h00);
        chk("grant", 8'(in_ep_grant), 8'h01);

        // table: 5-byte packet, NAK on empty, STALL / SETUP / zero-length DATA1
        for (int i = 0; i < NV; i++) begin
            reset = vecs[i].rst; in_ep_data_put = vecs[i].put; in_ep_data = vecs[i].data;
            in_ep_data_done = vecs[i].done; in_ep_stall = vecs[i].stall;
            setup_seen = vecs[i].setup; tx_pkt_start = vecs[i].start;
            tx_data_get = vecs[i].get; rx_ack = vecs[i].ack; tx_timeout = vecs[i].tmo;
            tick();
            chk($sformatf("row%0d free", i), 8'(in_ep_data_free), 8'(vecs[i].e_free));
            chk($sformatf("row%0d avail", i), 8'(tx_data_avail), 8'(vecs[i].e_avail));
            if (vecs[i].chk_data) chk($sformatf("row%0d data", i), tx_data, vecs[i].e_data);
            chk($sformatf("row%0d toggle", i), 8'(tx_data_toggle), 8'(vecs[i].e_tog));
            chk($sformatf("row%0d acked", i), 8'(in_ep_acked), 8'(vecs[i].e_acked));
            chk($sformatf("row%0d stall", i), 8'(tx_pkt_stall), 8'(vecs[i].e_stall));
            chk($sformatf("row%0d nak", i), 8'(tx_pkt_nak), 8'(vecs[i].e_nak));
            $display("vector %0d applied", i);
        end
        reset = 0; clr();

        // 32 bytes auto-close, then 3 more bytes with done on the last put
        do_reset();
        for (int i = 0; i < MAX; i++) put_byte(8'(8'h40 + i), 1'b0);
        chk("full free_buf1", 8'(in_ep_data_free), 8'h01);
        put_byte(8'hA0, 1'b0);
        put_byte(8'hA1, 1'b0);
        put_byte(8'hA2, 1'b1);
        chk("both_ready free", 8'(in_ep_data_free), 8'h00);
        start_token();
        chk("pkt32 toggle", 8'(tx_data_toggle), 8'h00);
        for (int i = 0; i < MAX; i++) exp_bytes[i] = 8'(8'h40 + i);
        drain(MAX, "pkt32");
        ack_packet("pkt32", 1'b1);
        chk("pkt32 free_after", 8'(in_ep_data_free), 8'h01);
        start_token();
        chk("pkt3 toggle", 8'(tx_data_toggle), 8'h01);
        exp_bytes[0] = 8'hA0; exp_bytes[1] = 8'hA1; exp_bytes[2] = 8'hA2;
        drain(3, "pkt3");
        ack_packet("pkt3", 1'b0);

        // timeout retransmit, then a re-token while waiting for the ACK
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_bytes[i] = 8'(8'h21 + i);
            put_byte(exp_bytes[i], 1'b0);
        end
        in_ep_data_done = 1; tick(); clr();
        start_token();
        chk("retry1 toggle", 8'(tx_data_toggle), 8'h00);
        drain(4, "retry1");
        tick();
        tx_timeout = 1; tick(); clr();
        chk("timeout acked", 8'(in_ep_acked), 8'h00);
        chk("timeout avail", 8'(tx_data_avail), 8'h00);
        start_token();
        chk("retry2 toggle", 8'(tx_data_toggle), 8'h00);
        drain(4, "retry2");
        tick();
        start_token();
        drain(4, "retry3");
        ack_packet("retry", 1'b1);

        // reset in the middle of an 8-byte transmit
        for (int i = 0; i < 8; i++) put_byte(8'(8'h31 + i), 1'b0);
        in_ep_data_done = 1; tick(); clr();
        start_token();
        chk("mid toggle", 8'(tx_data_toggle), 8'h01);
        chk("mid data0", tx_data, 8'h31);
        tx_data_get = 1; tick(); clr();
        chk("mid data1", tx_data, 8'h32);
        tx_data_get = 1; tick(); clr();
        reset = 1; tick(); reset = 0;
        chk("mid_rst avail", 8'(tx_data_avail), 8'h00);
        chk("mid_rst toggle", 8'(tx_data_toggle), 8'h00);
        chk("mid_rst free", 8'(in_ep_data_free), 8'h01);
        start_token();
        chk("mid_rst nak", 8'(tx_pkt_nak), 8'h01);
        $display("reset during transmit handled");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_in_ep_buffer.md
Name: usb_in_ep_buffer

Overview:
- Double-buffered (ping-pong) IN endpoint packet buffer between an endpoint client and the USB FS protocol engine's transmit path. The client is, for example, the control endpoint or the serial TX path.
- The client writes bytes with put/done into the fill buffer. The protocol engine drains the ready buffer when an IN token arrives.
- Tracks the DATA0/DATA1 toggle, retransmits on a missing ACK, and reports ACK/STALL/NAK.

Parameters:
- MAX_PKT_SIZE, 32, max bytes per packet; power of two, 8..64.
- PTR_W, $clog2(MAX_PKT_SIZE)+1, width of the byte count and pointer registers.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_ep_req  in  1  client requests the buffer
- in_ep_grant  out  1  = in_ep_req (single client)
- in_ep_data_free  out  1  fill buffer accepts a byte this cycle
- in_ep_data_put  in  1  write strobe
- in_ep_data  in  8  write byte
- in_ep_data_done  in  1  close the current packet (may be zero length)
- in_ep_stall  in  1  pulse: arm STALL
- in_ep_acked  out  1  1-cycle pulse: host ACKed a packet
- setup_seen  in  1  pulse: SETUP token received on this endpoint
- tx_pkt_start  in  1  pulse: IN token addressed to this endpoint
- tx_data_avail  out  1  byte available at tx_data
- tx_data_get  in  1  consume tx_data
- tx_data  out  8  show-ahead byte at the read pointer
- tx_data_toggle  out  1  PID select: 0=DATA0, 1=DATA1
- tx_pkt_stall  out  1  pulse: answer the token with STALL
- tx_pkt_nak  out  1  pulse: answer the token with NAK
- rx_ack  in  1  pulse: ACK handshake received
- tx_timeout  in  1  pulse: no handshake within the turnaround limit

Behaviour:
- Storage is 2*MAX_PKT_SIZE bytes, addressed {buf_idx, byte_idx}.
- Each buffer has a state FREE/FILL/READY/TX and a length register len[b].
- Pointers fill_sel and send_sel toggle independently.
- Reset values: all buffers FREE, fill_sel=send_sel=0, toggle=0, stall=0, TX FSM=TX_IDLE. All pulse outputs 0, tx_data_avail=0.

Fill side:
- in_ep_data_free = buf[fill_sel] in {FREE,FILL} && wr_cnt < MAX_PKT_SIZE.
- Put with free: write the byte, wr_cnt+1, and the buffer goes to FILL. Put without free is ignored; no overflow write occurs.
- The MAX_PKT_SIZE-th put auto-closes the buffer: READY, len=MAX_PKT_SIZE, fill_sel flips, wr_cnt=0.
- in_ep_data_done closes the buffer: READY, len=wr_cnt, flip.
  - Done in the same cycle as a put: the byte is included.
  - Done on a FREE buffer produces a zero-length READY.
  - Done while the fill buffer is READY/TX is ignored.

TX FSM:
- TX_IDLE, on tx_pkt_start:
  - stall=1: tx_pkt_stall pulse next cycle; stay in TX_IDLE.
  - buf[send_sel]==READY: rd_ptr=0, buffer to TX, go to TX_SEND.
  - Otherwise: tx_pkt_nak pulse.
- TX_SEND:
  - tx_data_avail = rd_ptr < len[send_sel].
  - tx_data = mem[{send_sel, rd_ptr}], combinational.
  - get advances rd_ptr. A get while avail=0 is ignored.
  - When rd_ptr == len, go to TX_WAIT_ACK. A zero-length packet reaches TX_WAIT_ACK the cycle after entering TX_SEND.
- TX_WAIT_ACK:
  - rx_ack: buffer FREE, toggle flips, in_ep_acked pulse, send_sel flips, go to TX_IDLE.
  - tx_timeout: buffer back to READY, toggle unchanged, go to TX_IDLE; the next token retransmits identical data.
  - tx_pkt_start: treated as a timeout followed by a fresh token, so the packet is resent from rd_ptr=0.
- rx_ack or tx_timeout in any state other than TX_WAIT_ACK is ignored.

Stall and SETUP:
- in_ep_stall sets stall, which is sticky until setup_seen or reset.
- setup_seen takes priority over every other event in the same cycle:
  - both buffers FREE, wr_cnt=0, fill_sel=send_sel=0;
  - stall=0, toggle=1, TX FSM to TX_IDLE;
  - no in_ep_acked pulse.
- Simultaneous put/done and TX activity on different buffers are independent.

Reset mid-operation returns to the reset values above in one cycle; partial data is discarded.

Decomposition:
- Package usb_pkg holds:
  - enum buf_state_t {FREE,FILL,READY,TX};
  - enum tx_state_t {TX_IDLE,TX_SEND,TX_WAIT_ACK};
  - PID constants DATA0/DATA1/NAK/STALL.
- Sub-module usb_in_pkt_ram: 2*MAX_PKT_SIZE x 8, one synchronous write port, one asynchronous read port; keeps RAM inference separate.

Test Plan:
- Put 5 bytes 0x11..0x15, then done, then tx_pkt_start:
  - avail stays high for exactly 5 gets, with tx_data 0x11..0x15;
  - rx_ack then gives in_ep_acked pulse and toggle 0->1.
- 32 puts with no done: the buffer auto-closes; data_free stays high for buffer 1.
  - Put 3 more bytes and done.
  - Two tokens with ACKs deliver 32 then 3 bytes, with toggles 0 then 1.
- Token with both buffers empty: tx_pkt_nak pulse, tx_data_avail stays 0.
- Send 4 bytes, then tx_timeout, then re-token:
  - the same 4 bytes resend with the same toggle;
  - the ACK then flips the toggle.
- in_ep_stall, then a token gives tx_pkt_stall; a second token gives tx_pkt_stall again.
  - setup_seen clears the stall, toggle=1.
  - done with no data, then token: zero-length DATA1 is sent; after the ACK, toggle=0.
- Reset asserted during TX_SEND after 2 of 8 bytes: the next cycle shows buffers FREE and toggle=0, and the next token gets a NAK.
